// File: rtl/memtoreg_pkg.sv
// Shared types and source-index names for the write-back source selector.
package memtoreg_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } memtoreg_state_t;

    localparam int SRC_REGB   = 0;
    localparam int SRC_LOAD   = 1;
    localparam int SRC_SHIFT  = 2;
    localparam int SRC_PC     = 3;
    localparam int SRC_LUI    = 4;
    localparam int SRC_ALUOUT = 5;
    localparam int SRC_MDR    = 6;
    localparam int SRC_CONST  = 7;

    localparam int CONST_VAL_DEF = 227;

endpackage

// File: rtl/memtoreg_mux_n.sv
// Combinational NSRC-way selector; out-of-range index yields zero.
// MEMTOREG_CONST_EN replaces the last source with the constant CONST_VAL.
module memtoreg_mux_n #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 8,
    parameter int CONST_VAL = memtoreg_pkg::CONST_VAL_DEF
) (
    input  logic [$clog2(NSRC)-1:0] sel,
    input  logic [NSRC*WIDTH-1:0]   entradas,
    output logic [WIDTH-1:0]        y
);
    localparam int SEL_W = $clog2(NSRC);

    always_comb begin
        y = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i)) y = entradas[i*WIDTH +: WIDTH];
        end
`ifdef MEMTOREG_CONST_EN
        if (sel == SEL_W'(NSRC-1)) y = WIDTH'(CONST_VAL);
`else
`endif
    end

endmodule

// File: rtl/memtoreg_wb_unit.sv
// Registered write-back source selector with memory-latency wait.
// Optional feature macro: MEMTOREG_CONST_EN (constant channel on index NSRC-1).
//   state    | meaning
//   IDLE     | accepting start; non-memory sources captured at once
//   WAIT_MEM | counting down MEM_LAT before sampling source MEM_SRC
module memtoreg_wb_unit
    import memtoreg_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 8,
    parameter int MEM_SRC   = SRC_LOAD,
    parameter int MEM_LAT   = 1,
    parameter int CONST_VAL = CONST_VAL_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(NSRC)-1:0] sel,
    input  logic [NSRC*WIDTH-1:0]   entradas,
    output logic [WIDTH-1:0]        wb_data,
    output logic                    wb_valid,
    output logic [$clog2(NSRC)-1:0] wb_sel,
    output logic                    busy,
    output logic                    start_err
);
    localparam int SEL_W = $clog2(NSRC);
    localparam int CNT_W = 4;
    localparam logic [SEL_W-1:0] MEM_SEL = SEL_W'(MEM_SRC);

    memtoreg_state_t    state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   data_n, mux_y;
    logic [SEL_W-1:0]   wsel_n, mux_sel;
    logic               valid_n, err_n;

    // While waiting, the mux is steered at the memory source so it is ready at terminal count.
    assign mux_sel = (state == WAIT_MEM) ? MEM_SEL : sel;

    memtoreg_mux_n #(
        .WIDTH     (WIDTH),
        .NSRC      (NSRC),
        .CONST_VAL (CONST_VAL)
    ) u_mux (
        .sel      (mux_sel),
        .entradas (entradas),
        .y        (mux_y)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = wb_data;
        wsel_n  = wb_sel;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    wsel_n = sel;
                    if (sel == MEM_SEL && MEM_LAT > 0) begin
                        state_n = WAIT_MEM;
                        cnt_n   = CNT_W'(MEM_LAT);
                    end else begin
                        data_n  = mux_y;
                        valid_n = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                err_n = start;
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    data_n  = mux_y;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_data   <= '0;
            wb_valid  <= 1'b0;
            wb_sel    <= '0;
            busy      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wb_data   <= data_n;
            wb_valid  <= valid_n;
            wb_sel    <= wsel_n;
            busy      <= (state_n == WAIT_MEM);
            start_err <= err_n;
        end
    end

endmodule

// File: tb/tb_memtoreg_wb_unit.sv
// Randomized and directed bench for memtoreg_wb_unit against a transaction-level model.
module tb_memtoreg_wb_unit;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [2:0]    sel;
    logic [255:0]  ent;

    logic [31:0]   a_data, b_data;
    logic [2:0]    a_sel, b_sel;
    logic          a_valid, a_busy, a_err, b_valid, b_busy, b_err;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    localparam int NS  [2] = '{8, 6};
    localparam int LAT [2] = '{3, 0};
    localparam int MSRC    = 1;

    logic [31:0] m_data [2];
    logic [2:0]  m_sel  [2];
    bit          m_valid[2], m_busy[2], m_err[2], m_pend[2];
    int          m_due  [2];

    always #5 clk = ~clk;

    memtoreg_wb_unit #(.WIDTH(32), .NSRC(8), .MEM_SRC(1), .MEM_LAT(3)) dut_a (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .entradas(ent),
        .wb_data(a_data), .wb_valid(a_valid), .wb_sel(a_sel), .busy(a_busy), .start_err(a_err)
    );

    memtoreg_wb_unit #(.WIDTH(32), .NSRC(6), .MEM_SRC(1), .MEM_LAT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .entradas(ent[191:0]),
        .wb_data(b_data), .wb_valid(b_valid), .wb_sel(b_sel), .busy(b_busy), .start_err(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input int k, input int idx);
        if (idx >= NS[k]) return 32'd0;
`ifdef MEMTOREG_CONST_EN
        if (idx == NS[k] - 1) return 32'd227;
`endif
        return ent[idx*32 +: 32];
    endfunction

    // One write-back transaction view: a request is either served now or due LAT edges later.
    task automatic model_edge(input int k);
        m_valid[k] = 1'b0;
        m_err[k]   = 1'b0;
        if (reset) begin
            m_data[k] = 0; m_sel[k] = 0; m_pend[k] = 1'b0;
        end else if (m_pend[k]) begin
            if (start) m_err[k] = 1'b1;
            if (edge_no == m_due[k]) begin
                m_data[k]  = src_val(k, MSRC);
                m_valid[k] = 1'b1;
                m_pend[k]  = 1'b0;
            end
        end else if (start) begin
            m_sel[k] = sel;
            if (int'(sel) == MSRC && LAT[k] > 0) begin
                m_pend[k] = 1'b1;
                m_due[k]  = edge_no + LAT[k];
            end else begin
                m_data[k]  = src_val(k, int'(sel));
                m_valid[k] = 1'b1;
            end
        end
        m_busy[k] = m_pend[k];
    endtask

    task automatic drive_cycle(input logic r, input logic s, input logic [2:0] sl);
        @(negedge clk);
        reset = r; start = s; sel = sl;
        @(posedge clk);
        edge_no++;
        model_edge(0);
        model_edge(1);
        #1;
        check_eq("a_data",  a_data,        m_data[0]);
        check_eq("a_valid", 32'(a_valid),  32'(m_valid[0]));
        check_eq("a_sel",   32'(a_sel),    32'(m_sel[0]));
        check_eq("a_busy",  32'(a_busy),   32'(m_busy[0]));
        check_eq("a_err",   32'(a_err),    32'(m_err[0]));
        check_eq("b_data",  b_data,        m_data[1]);
        check_eq("b_valid", 32'(b_valid),  32'(m_valid[1]));
        check_eq("b_sel",   32'(b_sel),    32'(m_sel[1]));
        check_eq("b_busy",  32'(b_busy),   32'(m_busy[1]));
        check_eq("b_err",   32'(b_err),    32'(m_err[1]));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 3'd0; ent = '0;
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 0; m_sel[k] = 0; m_valid[k] = 0; m_busy[k] = 0;
            m_err[k] = 0; m_pend[k] = 0; m_due[k] = 0;
        end
        drive_cycle(1'b1, 1'b0, 3'd0);
        drive_cycle(1'b1, 1'b1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b0, 3'd0);
            check_eq("idle_valid", 32'(a_valid), 32'd0);
            check_eq("idle_data",  a_data,       32'd0);
        end

        for (int i = 0; i < 8; i++) ent[i*32 +: 32] = 32'h1000 + i;
        drive_cycle(1'b0, 1'b1, 3'd5);
        check_eq("sel5_data",  a_data,       32'h1005);
        check_eq("sel5_sel",   32'(a_sel),   32'd5);
        check_eq("sel5_valid", 32'(a_valid), 32'd1);
        drive_cycle(1'b0, 1'b0, 3'd0);
        check_eq("sel5_pulse", 32'(a_valid), 32'd0);

        // memory wait; source changes before the capture edge
        drive_cycle(1'b0, 1'b1, 3'd1);
        check_eq("mem_busy0", 32'(a_busy), 32'd1);
        ent[32 +: 32] = 32'hDEAD;
        drive_cycle(1'b0, 1'b0, 3'd0);
        drive_cycle(1'b0, 1'b0, 3'd0);
        check_eq("mem_busy2",  32'(a_busy),  32'd1);
        check_eq("mem_novld",  32'(a_valid), 32'd0);
        drive_cycle(1'b0, 1'b0, 3'd0);
        check_eq("mem_data",   a_data,       32'hDEAD);
        check_eq("mem_valid",  32'(a_valid), 32'd1);
        check_eq("mem_idle",   32'(a_busy),  32'd0);

        // start while busy is rejected
        drive_cycle(1'b0, 1'b1, 3'd1);
        drive_cycle(1'b0, 1'b1, 3'd2);
        check_eq("err_pulse", 32'(a_err), 32'd1);
        check_eq("err_sel",   32'(a_sel), 32'd1);
        drive_cycle(1'b0, 1'b1, 3'd2);
        drive_cycle(1'b0, 1'b0, 3'd0);
        check_eq("err_valid", 32'(a_valid), 32'd1);
        check_eq("err_sel2",  32'(a_sel),   32'd1);
        drive_cycle(1'b0, 1'b0, 3'd0);
        check_eq("err_once",  32'(a_valid), 32'd0);

        ent[7*32 +: 32] = 32'h55;
        drive_cycle(1'b0, 1'b1, 3'd7);
`ifdef MEMTOREG_CONST_EN
        check_eq("const7", a_data, 32'd227);
`else
        check_eq("src7",   a_data, 32'h55);
`endif
        check_eq("b_oor_data",  b_data,       32'd0);
        check_eq("b_oor_valid", 32'(b_valid), 32'd1);
        drive_cycle(1'b0, 1'b1, 3'd6);
        check_eq("b_oor6_data",  b_data,       32'd0);
        check_eq("b_oor6_valid", 32'(b_valid), 32'd1);

        // reset aborts a pending memory wait
        drive_cycle(1'b0, 1'b1, 3'd1);
        drive_cycle(1'b0, 1'b0, 3'd0);
        drive_cycle(1'b1, 1'b1, 3'd3);
        check_eq("rst_busy",  32'(a_busy),  32'd0);
        check_eq("rst_valid", 32'(a_valid), 32'd0);
        check_eq("rst_data",  a_data,       32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 3'd0);
            check_eq("rst_novld", 32'(a_valid), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 8; j++) ent[j*32 +: 32] = $urandom;
            end
            drive_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
                        3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memtoreg_wb_unit.md
# memtoreg_wb_unit

Parametrised write-back source selector with a registered output and memory-latency wait, replacing the fixed 8-way combinational write-back mux on the register-file write path. The block selects one of NSRC data sources on a `start` command and presents the result on a registered `wb_data` with a one-cycle `wb_valid` pulse. When the memory-load source is selected, it waits MEM_LAT cycles for the data.

## Interface
- WIDTH, 32, data width of every source and of `wb_data`
- NSRC, 8, number of sources (2..16); SEL_W = $clog2(NSRC) is derived, not overridable
- MEM_SRC, 1, source index whose data arrives late (memory load)
- MEM_LAT, 1, cycles to wait before sampling source MEM_SRC (0..15)
- CONST_VAL, 227, value returned for index NSRC-1 when the constant channel is compiled in
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request one write-back selection
- `sel`  in  SEL_W  source index, sampled with `start`
- `entradas`  in  NSRC*WIDTH  flattened sources; source i = bits [i*WIDTH +: WIDTH]
- `wb_data`  out  WIDTH  registered selected data, held between results
- `wb_valid`  out  1  one-cycle pulse: `wb_data` updated this cycle
- `wb_sel`  out  SEL_W  index that produced the current `wb_data`
- `busy`  out  1  high while waiting on the memory source
- `start_err`  out  1  one-cycle pulse: `start` ignored because `busy`

## Operation
- FSM states: IDLE, WAIT_MEM.
- IDLE + `start`, and either `sel` != MEM_SRC or MEM_LAT == 0:
  - at that edge: `wb_data` <= selected source; `wb_sel` <= `sel`; `wb_valid` <= 1.
  - Stay in IDLE.
- IDLE + `start`, with `sel` == MEM_SRC and MEM_LAT > 0:
  - Go to WAIT_MEM; counter <= MEM_LAT; `wb_sel` <= `sel`.
- WAIT_MEM: counter decrements every edge. At the edge where counter == 1:
  - `wb_data` <= source MEM_SRC; `wb_valid` <= 1; return to IDLE.
- `busy` = (state == WAIT_MEM), registered.
- `start` while `busy`: no effect on FSM or data; `start_err` pulses for one cycle. This includes `start` in the last WAIT_MEM cycle. There is no queueing.
- `sel` >= NSRC (non-power-of-two NSRC): `wb_data` <= 0; `wb_valid` still pulses.
- `wb_valid` is 0 in every cycle that does not follow a capture. `wb_data` holds its last value indefinitely.

## Timing
- Reset values: `wb_data`=0, `wb_valid`=0, `wb_sel`=0, `busy`=0, `start_err`=0, state IDLE, counter 0.
- Latency, non-memory source: `start` at edge E0 gives `wb_valid` high in the cycle after E0. Throughput is one result per cycle with back-to-back `start`.
- Latency, memory source: `start` at E0; data sampled at E(MEM_LAT); `wb_valid` high in the cycle after E(MEM_LAT).
- The source value is sampled at the capture edge only. Changes to `entradas` at other times are ignored.
- `reset` during WAIT_MEM aborts the request: no `wb_valid`, and all outputs go to reset values at that edge. `reset` has priority over `start`.

## Configuration
- `MEMTOREG_CONST_EN` defined: index NSRC-1 returns CONST_VAL (WIDTH-extended, zero-filled). Input slice NSRC-1 of `entradas` is unused.
- Not defined: index NSRC-1 is an ordinary source taken from `entradas`.

## Structure
- Package `memtoreg_pkg`:
  - state enum `memtoreg_state_t` (IDLE, WAIT_MEM).
  - Source-index localparams: SRC_REGB=0, SRC_LOAD=1, SRC_SHIFT=2, SRC_PC=3, SRC_LUI=4, SRC_ALUOUT=5, SRC_MDR=6, SRC_CONST=7.
  - Default CONST_VAL.
- Sub-module `memtoreg_mux_n`: purely combinational WIDTH×NSRC selector, including the out-of-range-zero rule and the constant-channel macro. The top level holds the FSM, counter and output registers.

## Test plan
- Reset, then idle 5 cycles: all outputs 0, `wb_valid` never high.
- Defaults; `entradas`[i] = 0x1000+i; `start` with `sel`=5 → next cycle `wb_data`=0x1005, `wb_sel`=5, `wb_valid` high for exactly 1 cycle.
- MEM_LAT=3; `start` with `sel`=1 at E0; source 1 changes to 0xDEAD before E3 → `busy` high for 3 cycles; `wb_valid` in the cycle after E3 with `wb_data`=0xDEAD.
- `start` again during WAIT_MEM with `sel`=2 → `start_err` pulse, `wb_sel` stays 1, exactly one `wb_valid`.
- `MEMTOREG_CONST_EN` defined, `sel`=7 → `wb_data`=227. Undefined with source 7 = 0x55 → `wb_data`=0x55.
- `reset` asserted at E2 of a MEM_LAT=3 wait → no `wb_valid`, `busy`=0 next cycle. NSRC=6 with `sel`=6 → `wb_data`=0 and `wb_valid` pulses.
